vigenere_key_scheduler: RTL and testbench

//  Upstream feeder for the Vigenere encryptor. Holds a loaded key string, accepts a

---
 rtl/vigenere_pkg.sv | 35 +++
 rtl/vigenere_key_buf.sv | 63 ++++++
 rtl/vigenere_key_scheduler.sv | 155 +++++++++++++++
 tb/tb_vigenere_key_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vigenere_pkg.sv
// Shared constants, scheduler state type and ASCII helpers for the Vigenere pipeline.
package vigenere_pkg;

  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_Z = 8'h5A;
  localparam logic [7:0] ASCII_a = 8'h61;
  localparam logic [7:0] ASCII_z = 8'h7A;

  // Distance between a lowercase letter and its uppercase form.
  localparam logic [7:0] CASE_DELTA = 8'h20;

  typedef enum logic [1:0] {
    StEmpty,
    StLoading,
    StRun
  } sched_state_e;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= ASCII_A) && (c <= ASCII_Z);
  endfunction

  function automatic logic is_lower(input logic [7:0] c);
    return (c >= ASCII_a) && (c <= ASCII_z);
  endfunction

  function automatic logic is_letter(input logic [7:0] c);
    return is_upper(c) || is_lower(c);
  endfunction

  // Lowercase letters map to uppercase; everything else is returned unchanged.
  function automatic logic [7:0] fold_upper(input logic [7:0] c);
    return is_lower(c) ? (c - CASE_DELTA) : c;
  endfunction

endpackage

// File: rtl/vigenere_key_buf.sv
// Key character store: one write port that appends, one asynchronous read port.
// Owns the key length and rejects non-letters and writes past the end.
module vigenere_key_buf
  import vigenere_pkg::*;
#(
  parameter int unsigned MAX_KEY_LEN = 16,
  localparam int unsigned IDX_W = $clog2(MAX_KEY_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             wr_req_i,
  input  logic [7:0]       wr_char_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [7:0]       rd_char_o,
  output logic [IDX_W:0]   len_o,
  output logic [IDX_W:0]   len_next_o,
  output logic             wr_accept_o,
  output logic             wr_err_o
);

  logic [7:0]     key_mem_q [MAX_KEY_LEN];
  logic [IDX_W:0] len_q, len_d;
  logic           full;
  logic           letter;

  assign full   = (len_q == (IDX_W + 1)'(MAX_KEY_LEN));
  assign letter = is_letter(wr_char_i);

  assign wr_accept_o = wr_req_i && letter && !full;
  assign wr_err_o    = wr_req_i && (!letter || full);

  // Length update; clear beats a simultaneous write.
  always_comb begin
    len_d = len_q;
    if (clear_i) begin
      len_d = '0;
    end else if (wr_accept_o) begin
      len_d = len_q + (IDX_W + 1)'(1);
    end
  end

  assign len_next_o = len_d;
  assign len_o      = len_q;
  assign rd_char_o  = key_mem_q[rd_idx_i];

  // Length register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
    end else begin
      len_q <= len_d;
    end
  end

  // Key storage has no reset; slots beyond len_q are never read as valid key data.
  always_ff @(posedge clk) begin
    if (wr_accept_o) begin
      key_mem_q[len_q[IDX_W-1:0]] <= fold_upper(wr_char_i);
    end
  end

endmodule

// File: rtl/vigenere_key_scheduler.sv
// Pairs each message byte with the current key character for the encryptor.
// Key position advances on letters only and wraps over the loaded key length.
module vigenere_key_scheduler
  import vigenere_pkg::*;
#(
  parameter int unsigned MAX_KEY_LEN = 16,
  localparam int unsigned IDX_W = $clog2(MAX_KEY_LEN)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           key_wr_en,
  input  logic [7:0]     key_wr_char,
  input  logic           key_commit,
  input  logic           key_clear,
  output logic [IDX_W:0] key_len,
  output logic           key_err,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [7:0]     in_char,
  input  logic           in_sop,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [7:0]     out_msg_char,
  output logic [7:0]     out_key_char,
  output logic           out_bypass
);

  sched_state_e   state_q, state_d;
  logic [IDX_W-1:0] pos_q, pos_d;
  logic           err_q, err_d;
  logic           out_valid_q, out_valid_d;
  logic [7:0]     out_msg_q, out_msg_d;
  logic [7:0]     out_key_q, out_key_d;
  logic           out_bypass_q, out_bypass_d;

  logic           wr_req;
  logic           wr_accept;
  logic           wr_err;
  logic [IDX_W:0] len_cur;
  logic [IDX_W:0] len_next;
  logic [7:0]     key_rd_char;
  logic [IDX_W-1:0] use_pos;
  logic           letter;
  logic           xfer;
  logic           pos_wrap;

  // Key writes are only meaningful before the key is committed.
  assign wr_req   = key_wr_en && !key_clear && (state_q != StRun);
  assign use_pos  = in_sop ? '0 : pos_q;
  assign letter   = is_letter(in_char);
  assign in_ready = (state_q == StRun) && !key_clear && (!out_valid_q || out_ready);
  assign xfer     = in_valid && in_ready;
  assign pos_wrap = ({1'b0, use_pos} == (len_cur - (IDX_W + 1)'(1)));

  vigenere_key_buf #(
    .MAX_KEY_LEN(MAX_KEY_LEN)
  ) u_key_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (key_clear),
    .wr_req_i   (wr_req),
    .wr_char_i  (key_wr_char),
    .rd_idx_i   (use_pos),
    .rd_char_o  (key_rd_char),
    .len_o      (len_cur),
    .len_next_o (len_next),
    .wr_accept_o(wr_accept),
    .wr_err_o   (wr_err)
  );

  // Next state for FSM, error flag, key position and the output register.
  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    pos_d        = pos_q;
    out_valid_d  = out_valid_q;
    out_msg_d    = out_msg_q;
    out_key_d    = out_key_q;
    out_bypass_d = out_bypass_q;

    if (key_clear) begin
      state_d      = StEmpty;
      err_d        = 1'b0;
      pos_d        = '0;
      out_valid_d  = 1'b0;
      out_msg_d    = 8'h00;
      out_key_d    = 8'h00;
      out_bypass_d = 1'b0;
    end else begin
      if (key_wr_en && (state_q == StRun)) begin
        err_d = 1'b1;
      end
      if (wr_err) begin
        err_d = 1'b1;
      end
      if (wr_accept && (state_q == StEmpty)) begin
        state_d = StLoading;
      end
      // Commit sees the length including a write landing in the same cycle.
      if (key_commit && (state_q != StRun)) begin
        if (len_next != '0) begin
          state_d = StRun;
        end else begin
          err_d = 1'b1;
        end
      end

      if (xfer) begin
        out_valid_d = 1'b1;
        if (letter) begin
          out_msg_d    = fold_upper(in_char);
          out_key_d    = key_rd_char;
          out_bypass_d = 1'b0;
          pos_d        = pos_wrap ? '0 : (use_pos + IDX_W'(1));
        end else begin
          out_msg_d    = in_char;
          out_key_d    = ASCII_A;
          out_bypass_d = 1'b1;
          pos_d        = use_pos;
        end
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StEmpty;
      err_q        <= 1'b0;
      pos_q        <= '0;
      out_valid_q  <= 1'b0;
      out_msg_q    <= 8'h00;
      out_key_q    <= 8'h00;
      out_bypass_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      pos_q        <= pos_d;
      out_valid_q  <= out_valid_d;
      out_msg_q    <= out_msg_d;
      out_key_q    <= out_key_d;
      out_bypass_q <= out_bypass_d;
    end
  end

  assign key_len      = len_cur;
  assign key_err      = err_q;
  assign out_valid    = out_valid_q;
  assign out_msg_char = out_msg_q;
  assign out_key_char = out_key_q;
  assign out_bypass   = out_bypass_q;

endmodule

// File: tb/tb_vigenere_key_scheduler.sv
// Scoreboard bench for the Vigenere key scheduler with a string-level reference model.
module tb_vigenere_key_scheduler;

  localparam int MAXK = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_wr_en, key_commit, key_clear;
  logic [7:0] key_wr_char;
  logic [4:0] key_len;
  logic       key_err;
  logic       in_valid, in_ready, in_sop;
  logic [7:0] in_char;
  logic       out_valid, out_ready, out_bypass;
  logic [7:0] out_msg_char, out_key_char;

  vigenere_key_scheduler #(
    .MAX_KEY_LEN(MAXK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_wr_en   (key_wr_en),
    .key_wr_char (key_wr_char),
    .key_commit  (key_commit),
    .key_clear   (key_clear),
    .key_len     (key_len),
    .key_err     (key_err),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_char     (in_char),
    .in_sop      (in_sop),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_msg_char(out_msg_char),
    .out_key_char(out_key_char),
    .out_bypass  (out_bypass)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] m;
    logic [7:0] k;
    logic       b;
  } exp_t;

  exp_t        sb[$];
  byte unsigned mkey[$];
  int          mpos;
  int          n_tests;
  int          n_fail;
  int          stalls;
  int          bp_mode;
  int          bp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_up(input byte unsigned c);
    return c >= "A" && c <= "Z";
  endfunction

  function automatic bit is_lo(input byte unsigned c);
    return c >= "a" && c <= "z";
  endfunction

  // Reference: each accepted byte gets key[use]; letters step the position mod key length.
  function automatic void model_push(input byte unsigned c, input bit sop);
    int   use_p;
    exp_t e;
    use_p = sop ? 0 : mpos;
    if (is_up(c) || is_lo(c)) begin
      e.m  = is_lo(c) ? c - 8'd32 : c;
      e.k  = mkey[use_p];
      e.b  = 1'b0;
      mpos = (use_p + 1) % mkey.size();
    end else begin
      e.m  = c;
      e.k  = "A";
      e.b  = 1'b1;
      mpos = use_p;
    end
    sb.push_back(e);
  endfunction

  // Downstream ready pattern: 0 always, 1 random, 2 held low, 3 low for three beats.
  always @(posedge clk) begin
    #1;
    bp_cnt++;
    case (bp_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 2) != 0);
      3:       out_ready = !(bp_cnt >= 4 && bp_cnt <= 6);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on each handshake, checks stability under backpressure.
  logic [16:0] prev_out;
  logic        phold = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (phold && out_valid)
        chk("hold_stable", {out_msg_char, out_key_char, out_bypass}, prev_out);
      if (out_valid && !out_ready) chk("in_ready_bp", in_ready, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pair: got %0h expected none", out_msg_char);
        end else begin
          e = sb.pop_front();
          chk("pair", {out_msg_char, out_key_char, out_bypass}, {e.m, e.k, e.b});
        end
      end
      phold    = out_valid && !out_ready;
      prev_out = {out_msg_char, out_key_char, out_bypass};
    end else begin
      phold = 1'b0;
    end
  end

  task automatic send_byte(input byte unsigned c, input bit sop);
    bit done;
    done     = 0;
    in_valid = 1'b1;
    in_char  = c;
    in_sop   = sop;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        model_push(c, sop);
        done = 1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got no in_ready expected in_ready=1");
    end
  endtask

  task automatic send_str(input string s, input bit first_sop);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], first_sop && i == 0);
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic load_char(input byte unsigned c);
    key_wr_en   = 1'b1;
    key_wr_char = c;
    @(posedge clk);
    #1;
    key_wr_en = 1'b0;
    if ((is_up(c) || is_lo(c)) && mkey.size() < MAXK) mkey.push_back(is_lo(c) ? c - 8'd32 : c);
  endtask

  task automatic load_key(input string s);
    for (int i = 0; i < s.len(); i++) load_char(s[i]);
  endtask

  task automatic commit();
    key_commit = 1'b1;
    @(posedge clk);
    #1;
    key_commit = 1'b0;
  endtask

  task automatic clear();
    key_clear = 1'b1;
    @(posedge clk);
    #1;
    key_clear = 1'b0;
    mkey.delete();
    mpos = 0;
    sb.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  byte unsigned bnd[6] = '{8'h40, 8'h5B, 8'h60, 8'h7B, 8'h2D, 8'h20};

  initial begin
    n_tests = 0; n_fail = 0; stalls = 0; bp_mode = 0; bp_cnt = 0; mpos = 0;
    rst_n = 1'b0; key_wr_en = 0; key_wr_char = 0; key_commit = 0; key_clear = 0;
    in_valid = 0; in_char = 0; in_sop = 0; out_ready = 0;

    #13;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_key_len", key_len, 0);
    chk("rst_key_err", key_err, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_chars", {out_msg_char, out_key_char, out_bypass}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // LEMON / ATTACKATDAWN, back-to-back
    load_key("LEMON");
    chk("lemon_len", key_len, 5);
    commit();
    chk("lemon_err", key_err, 0);
    stalls = 0;
    send_str("ATTACKATDAWN", 1);
    chk("lemon_stalls", stalls, 0);
    drain();

    // Lowercase key, bypass does not advance the key
    clear();
    load_key("ab");
    commit();
    send_str("a-b", 1);
    drain();

    // Three-beat backpressure mid-stream
    clear();
    load_key("LEMON");
    commit();
    bp_cnt  = 0;
    bp_mode = 3;
    send_str("ATTACKATDAWN", 1);
    drain();
    bp_mode = 0;

    // Error cases
    clear();
    load_key("ABCDEFGHIJKLMNOPQ");
    chk("ovf_len", key_len, MAXK);
    chk("ovf_err", key_err, 1);
    clear();
    chk("clr_err", key_err, 0);
    load_char("7");
    chk("nonletter_err", key_err, 1);
    chk("nonletter_len", key_len, 0);
    clear();
    commit();
    chk("empty_commit_err", key_err, 1);
    chk("empty_commit_rdy", in_ready, 0);
    load_key("XY");
    commit();
    load_char("Z");
    chk("run_write_len", key_len, 2);
    clear();

    // key_clear with a pending pair and a valid input in the same cycle
    load_key("KEY");
    commit();
    bp_mode   = 2;
    out_ready = 1'b0;
    send_byte("Q", 1);
    in_valid  = 1'b1;
    in_char   = "R";
    key_clear = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", in_ready, 0);
    chk("clr_pending", out_valid, 1);
    @(posedge clk);
    #1;
    key_clear = 1'b0;
    in_valid  = 1'b0;
    chk("clr_out_valid", out_valid, 0);
    chk("clr_key_len", key_len, 0);
    chk("clr_in_ready2", in_ready, 0);
    sb.delete(); mkey.delete(); mpos = 0;
    commit();
    chk("clr_state_empty", key_err, 1);
    clear();
    bp_mode = 0;

    // Random keys and messages
    for (int r = 0; r < 6; r++) begin
      int n;
      clear();
      n = $urandom_range(1, MAXK);
      for (int i = 0; i < n; i++) load_char(8'($urandom_range(0, 25)) + ($urandom_range(0, 1) ? "a" : "A"));
      commit();
      chk("rnd_len", key_len, n);
      chk("rnd_err", key_err, 0);
      bp_mode = r % 2;
      for (int i = 0; i < 40; i++) begin
        byte unsigned c;
        case ($urandom_range(0, 3))
          0:       c = 8'($urandom_range(0, 25)) + "A";
          1:       c = 8'($urandom_range(0, 25)) + "a";
          2:       c = bnd[$urandom_range(0, 5)];
          default: c = 8'($urandom_range(32, 126));
        endcase
        send_byte(c, i == 0 || $urandom_range(0, 7) == 0);
      end
      in_valid = 1'b0;
      drain();
    end
    bp_mode = 0;

    // Asynchronous reset mid-stream
    clear();
    load_key("LEMON");
    commit();
    send_str("ATT", 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_chars", {out_msg_char, out_key_char, out_bypass}, 0);
    chk("arst_key_len", key_len, 0);
    chk("arst_in_ready", in_ready, 0);
    sb.delete(); mkey.delete(); mpos = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    load_key("LEMON");
    commit();
    send_str("ATTACKAT", 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
